// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: requester/response bundle for the ALU issue controller.
// Two requester channels (req0_*, req1_*) and one response channel (rsp_*).
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// A source holds valid and its payload stable until the transfer; it may
// drop valid before ready, in which case nothing is transferred.
interface alu_issue_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [4:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;

   logic             req1_valid;
   logic             req1_ready;
   logic [4:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;
   logic [3:0]       rsp_flags;
   logic             rsp_err;

   // Requester/consumer side
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err
   );

   // Controller side
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: round-robin issue front-end for the shared combinational ALU.
// Grants one of two requesters in IDLE, holds the op on the ALU pins for its
// latency (EXEC), then presents the registered result until consumed (RESP).
// Also keeps the architectural sticky {N,Z,V,C} register.
// Optional macro ALU_ILLEGAL_OP_TRAP_EN: illegal opcodes (0 or >19) bypass
// the ALU and return an error response with zero data/flags.
module alu_issue_ctrl #(
   parameter int WIDTH      = 32,
   parameter int FAST_LAT   = 1,
   parameter int MULDIV_LAT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_issue_ctrl_if.slave  bus,
   output logic [WIDTH-1:0] alu_in_1,
   output logic [WIDTH-1:0] alu_in_2,
   output logic [4:0]       alu_op,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_n,
   input  logic             alu_z,
   input  logic             alu_v,
   input  logic             alu_c,
   output logic [3:0]       flags_q,
   output logic             busy
);

   // Counter only needs to hold latency-1 of the slower class.
   localparam int MAX_LAT = (FAST_LAT > MULDIV_LAT) ? FAST_LAT : MULDIV_LAT;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] FAST_CNT   = CNT_W'(FAST_LAT - 1);
   localparam logic [CNT_W-1:0] MULDIV_CNT = CNT_W'(MULDIV_LAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // FSM and datapath registers
   state_t           state_q, state_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic [4:0]       alu_op_q, alu_op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             id_q, id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [3:0]       rsp_flags_q, rsp_flags_d;
   logic [3:0]       arch_flags_q, arch_flags_d;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
   logic             rsp_err_q, rsp_err_d;
`endif

   // Arbitration signals
   logic             any_valid;
   logic             gnt_id;
   logic [4:0]       gnt_op;
   logic [WIDTH-1:0] gnt_a;
   logic [WIDTH-1:0] gnt_b;
   logic             gnt_muldiv;
   logic             trap_hit;

   assign any_valid = bus.req0_valid | bus.req1_valid;

   // Round-robin winner: rr_ptr breaks ties, a lone requester always wins.
   always_comb begin
      gnt_id = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         gnt_id = rr_ptr_q;
      end else if (bus.req1_valid) begin
         gnt_id = 1'b1;
      end
   end

   assign gnt_op     = gnt_id ? bus.req1_op : bus.req0_op;
   assign gnt_a      = gnt_id ? bus.req1_a  : bus.req0_a;
   assign gnt_b      = gnt_id ? bus.req1_b  : bus.req0_b;
   // mul/div family occupies opcodes 4..7
   assign gnt_muldiv = (gnt_op[4:2] == 3'b001);

`ifdef ALU_ILLEGAL_OP_TRAP_EN
   assign trap_hit = (gnt_op == 5'd0) || (gnt_op > 5'd19);
`else
   assign trap_hit = 1'b0;
`endif

   // Ready is a pure function of the current grant, only while idle.
   assign bus.req0_ready = (state_q == IDLE) && any_valid && !gnt_id;
   assign bus.req1_ready = (state_q == IDLE) && any_valid &&  gnt_id;

   // Next-state and next-output computation for the issue FSM.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      alu_op_d     = alu_op_q;
      a_d          = a_q;
      b_d          = b_q;
      id_d         = id_q;
      cnt_d        = cnt_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_flags_d  = rsp_flags_q;
      arch_flags_d = arch_flags_q;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
      rsp_err_d    = rsp_err_q;
`endif

      case (state_q)
         IDLE: begin
            if (any_valid) begin
               a_d      = gnt_a;
               b_d      = gnt_b;
               id_d     = gnt_id;
               rr_ptr_d = ~gnt_id;
               cnt_d    = gnt_muldiv ? MULDIV_CNT : FAST_CNT;
               if (trap_hit) begin
                  // Illegal op never reaches the ALU; respond next cycle.
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_id_d    = gnt_id;
                  rsp_data_d  = '0;
                  rsp_flags_d = 4'b0000;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
                  rsp_err_d   = 1'b1;
`endif
               end else begin
                  state_d  = EXEC;
                  alu_op_d = gnt_op;
               end
            end
         end

         EXEC: begin
            if (cnt_q == '0) begin
               state_d      = RESP;
               alu_op_d     = 5'd0;
               rsp_valid_d  = 1'b1;
               rsp_id_d     = id_q;
               rsp_data_d   = alu_out;
               rsp_flags_d  = {alu_n, alu_z, alu_v, alu_c};
               arch_flags_d = {alu_n, alu_z, alu_v, alu_c};
`ifdef ALU_ILLEGAL_OP_TRAP_EN
               rsp_err_d    = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         RESP: begin
            if (bus.rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end

         default: begin
            state_d  = IDLE;
            alu_op_d = 5'd0;
         end
      endcase
   end

   // State and registered outputs; reset discards any op in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= 1'b0;
         alu_op_q     <= 5'd0;
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= 1'b0;
         cnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
         rsp_flags_q  <= 4'b0000;
         arch_flags_q <= 4'b0100;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
         rsp_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         alu_op_q     <= alu_op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         id_q         <= id_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_flags_q  <= rsp_flags_d;
         arch_flags_q <= arch_flags_d;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
         rsp_err_q    <= rsp_err_d;
`endif
      end
   end

   // alu_op_q is non-zero only in EXEC, so the ALU idles on its default op.
   assign alu_op        = alu_op_q;
   assign alu_in_1      = a_q;
   assign alu_in_2      = b_q;
   assign flags_q       = arch_flags_q;
   assign busy          = (state_q != IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_flags = rsp_flags_q;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
   assign bus.rsp_err   = rsp_err_q;
`else
   assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: bench for alu_issue_ctrl with a stub combinational ALU.
// Honours ALU_ILLEGAL_OP_TRAP_EN when defined for the build.
module tb_alu_issue_ctrl;
   localparam int W          = 32;
   localparam int FAST_LAT   = 1;
   localparam int MULDIV_LAT = 3;
   localparam int EW         = W + 6;   // {err, id, flags[3:0], data}

   // Clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_issue_ctrl_if #(.WIDTH(W)) bus();

   logic [W-1:0] alu_in_1, alu_in_2, alu_out;
   logic [4:0]   alu_op;
   logic         alu_n, alu_z, alu_v, alu_c;
   logic [3:0]   flags_q;
   logic         busy;

   alu_issue_ctrl #(
      .WIDTH(W), .FAST_LAT(FAST_LAT), .MULDIV_LAT(MULDIV_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_op(alu_op),
      .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
      .alu_c(alu_c), .flags_q(flags_q), .busy(busy)
   );

   int tests_run = 0;
   int tests_failed = 0;
   logic [EW-1:0] exp_q[$];
   logic [3:0] exp_flags = 4'b0100;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Stub ALU: returns {out, N, Z, V, C}; opcode 0 and >19 give zero.
   function automatic logic [W+3:0] alu_model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0]     wide;
      logic [2*W-1:0] p;
      logic [W-1:0]   r;
      logic           v, c;
      r = '0; v = 1'b0; c = 1'b0;
      wide = {1'b0, a} + {1'b0, b};
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      case (op)
         5'd1: begin r = wide[W-1:0]; c = wide[W]; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
         5'd2: begin r = a - b; c = (a >= b); v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
         5'd3: r = a & b;
         5'd4: r = p[W-1:0];
         5'd5: r = p[2*W-1:W];
         5'd6: r = (b == '0) ? '1 : a / b;
         5'd7: r = (b == '0) ? a : a % b;
         5'd8: r = a | b;
         5'd9: r = a ^ b;
         5'd10: r = a << b[4:0];
         5'd11: r = a >> b[4:0];
         5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19:
            r = a ^ b ^ {{(W-5){1'b0}}, op};
         default: r = '0;
      endcase
      return {r, r[W-1], (r == '0), v, c};
   endfunction

   always_comb {alu_out, alu_n, alu_z, alu_v, alu_c} = alu_model(alu_op, alu_in_1, alu_in_2);

   function automatic bit is_illegal(input logic [4:0] op);
      return (op == 5'd0) || (op > 5'd19);
   endfunction

   function automatic logic [EW-1:0] make_exp(input bit id, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W+3:0] m;
`ifdef ALU_ILLEGAL_OP_TRAP_EN
      if (is_illegal(op)) return {1'b1, id, 4'b0000, {W{1'b0}}};
`endif
      m = alu_model(op, a, b);
      return {1'b0, id, m[3:0], m[W+3:4]};
   endfunction

   // Accept-to-rsp_valid cycle count
   function automatic int exp_lat(input logic [4:0] op);
`ifdef ALU_ILLEGAL_OP_TRAP_EN
      if (is_illegal(op)) return 1;
`endif
      if (op >= 5'd4 && op <= 5'd7) return MULDIV_LAT + 1;
      return FAST_LAT + 1;
   endfunction

   // Scoreboard: push on accepted request, pop on consumed response.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (!rst_n) begin
         exp_q.delete();
         exp_flags = 4'b0100;
      end else begin
         if (busy) check("ready_while_busy", {62'd0, bus.req0_ready, bus.req1_ready}, 64'd0);
         if (bus.req0_valid && bus.req0_ready)
            exp_q.push_back(make_exp(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
         if (bus.req1_valid && bus.req1_ready)
            exp_q.push_back(make_exp(1'b1, bus.req1_op, bus.req1_a, bus.req1_b));
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_data", bus.rsp_data, e[W-1:0]);
               check("rsp_flags", bus.rsp_flags, e[W+3:W]);
               check("rsp_id", bus.rsp_id, e[W+4]);
               check("rsp_err", bus.rsp_err, e[W+5]);
               if (!e[W+5]) exp_flags = e[W+3:W];
               check("flags_q", flags_q, exp_flags);
            end
         end
      end
   end

   // Driver tasks
   task automatic set_req(input bit id, input logic v, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (!id) begin
         bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Issue one op, check grant wait (if exp_wait>=0), operand hold and latency.
   task automatic run_op(input bit id, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int exp_wait);
      int  n;
      bit  got;
      set_req(id, 1'b1, op, a, b);
      got = 1'b0;
      n = 0;
      while (!got && n < 30) begin
         @(negedge clk);
         n++;
         got = id ? bus.req1_ready : bus.req0_ready;
      end
      if (!got) begin
         check("accept_timeout", 64'd0, 64'd1);
         set_req(id, 1'b0, op, a, b);
         return;
      end
      if (exp_wait >= 0) check("accept_wait", n, exp_wait);
      @(posedge clk);
      #1 set_req(id, 1'b0, op, a, b);
      n = 0;
      got = 1'b0;
      while (!got && n < 30) begin
         @(negedge clk);
         n++;
         if (bus.rsp_valid) got = 1'b1;
         else begin
            check("alu_op_hold", alu_op, op);
            check("alu_in_hold", {alu_in_1, alu_in_2}, {a, b});
         end
      end
      check("latency", n, exp_lat(op));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [4:0] ops_tbl [12];
      bit got, gid;
      bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
      bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
      bus.rsp_ready = 0;
      ops_tbl = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd8, 5'd9, 5'd12, 5'd19, 5'd20, 5'd31};

      // Reset state
      @(negedge clk);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_data", bus.rsp_data, 0);
      check("rst_rsp_flags", bus.rsp_flags, 0);
      check("rst_rsp_id", bus.rsp_id, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_alu_in", {alu_in_1, alu_in_2}, 0);
      check("rst_flags_q", flags_q, 4'b0100);
      check("rst_busy", busy, 0);
      check("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // ADD 5+7 from req0
      bus.rsp_ready = 1'b1;
      run_op(1'b0, 5'd1, 32'd5, 32'd7, 1);
      check("t1_flags_q", flags_q, 4'b0000);

      // Round robin with both requesters valid continuously
      do_reset();
      set_req(1'b0, 1'b1, 5'd3, $urandom, $urandom);
      set_req(1'b1, 1'b1, 5'd3, $urandom, $urandom);
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = bus.req0_ready || bus.req1_ready;
         end
         gid = bus.req1_ready;
         check("rr_grant", {got, gid}, {1'b1, k[0]});
         @(posedge clk);
         #1 set_req(gid, 1'b1, 5'd3, $urandom, $urandom);
      end
      set_req(1'b0, 1'b0, 5'd3, 0, 0);
      set_req(1'b1, 1'b0, 5'd3, 0, 0);
      repeat (6) @(negedge clk);
      check("rr_drain", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // MUL from req1
      run_op(1'b1, 5'd4, 32'h0000_FFFF, 32'd2, 1);

      // Overflowing ADD under back-pressure
      bus.rsp_ready = 1'b0;
      run_op(1'b0, 5'd1, 32'h7FFF_FFFF, 32'd1, 1);
      set_req(1'b0, 1'b1, 5'd2, 32'd10, 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", bus.rsp_valid, 1);
         check("bp_data", bus.rsp_data, 32'h8000_0000);
         check("bp_flags", bus.rsp_flags, 4'b1010);
         check("bp_req0_ready", bus.req0_ready, 0);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      run_op(1'b0, 5'd2, 32'd10, 32'd3, 2);

      // Reset in the middle of a DIV
      set_req(1'b0, 1'b1, 5'd6, 32'd100, 32'd7);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         got = bus.req0_ready;
      end
      check("div_accept", got, 1);
      @(posedge clk);
      #1 set_req(1'b0, 1'b0, 5'd6, 32'd100, 32'd7);
      @(negedge clk);
      check("div_busy", busy, 1);
      check("div_alu_op", alu_op, 5'd6);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_alu_op", alu_op, 0);
      @(negedge clk);
      check("mid_rst_flags_q", flags_q, 4'b0100);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_no_rsp", bus.rsp_valid, 0);
      end
      @(posedge clk);
      #1;
      run_op(1'b0, 5'd2, 32'd3, 32'd5, 1);

      // Illegal opcode
      run_op(1'b1, 5'd31, 32'h1234, 32'h5678, 1);

      // Opcode boundaries and random traffic
      foreach (ops_tbl[i]) run_op(1'($urandom_range(0, 1)), ops_tbl[i], $urandom, $urandom, 1);
      for (int i = 0; i < 10; i++)
         run_op(1'($urandom_range(0, 1)), ops_tbl[$urandom_range(0, 11)], $urandom, 32'($urandom_range(0, 40)), 1);

      repeat (3) @(negedge clk);
      check("final_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
